// File: rtl/spi_rx.sv
// SPI peripheral-side receiver: oversamples SCLK/MOSI/CS_n on i_clock, assembles
// MSB-first words of 1-16 bits and hands them off through a toggle req/ack pair.
module spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [3:0]  i_data_width,
  input  logic        i_cpol,
  input  logic        i_cpha,
  input  logic        i_sclk,
  input  logic        i_mosi,
  input  logic        i_cs_n,
  input  logic        i_data_ack,
  input  logic        i_overrun_clr,
  output logic [15:0] o_data,
  output logic        o_data_req,
  output logic        o_overrun,
  output logic        o_busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, vld_pipe;
  logic                   sclk_d, armed;
  logic [4:0]             cnt;
  logic [14:0]            shreg;

  logic        sclk_s, mosi_s, cs_s;
  logic        sample_edge, word_done, ovr_set;
  logic [4:0]  eff_width;
  logic [15:0] shift_val;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sample_edge = (i_cpol == i_cpha) ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
  assign eff_width   = (i_data_width == 4'd0) ? 5'd16 : {1'b0, i_data_width};
  assign shift_val   = {shreg, mosi_s};
  assign word_done   = (state == SHIFT) && !cs_s && sample_edge && (cnt == 5'd1);
  assign ovr_set     = word_done && (o_data_req != i_data_ack);
  assign o_busy      = (state == SHIFT);

  // vld_pipe marks when the sync chain holds real pin values rather than reset
  // values; only a CS_n high seen after that arms the receiver, so a frame
  // already in progress at reset release is ignored.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '1;
      cs_sync   <= '1;
      vld_pipe  <= '0;
      sclk_d    <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      if (vld_pipe[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (armed && !cs_s) state_nxt = SHIFT;
      SHIFT:   if (cs_s)           state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt        <= 5'd16;
      shreg      <= '0;
      o_data     <= '0;
      o_data_req <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      if (state != SHIFT || cs_s) begin
        cnt   <= eff_width;
        shreg <= '0;
      end else if (sample_edge) begin
        if (cnt == 5'd1) begin
          // word complete: reload in the same cycle so words can run back to back
          cnt   <= eff_width;
          shreg <= '0;
          if (!ovr_set) begin
            o_data     <= shift_val;
            o_data_req <= ~o_data_req;
          end
        end else begin
          cnt   <= cnt - 5'd1;
          shreg <= shift_val[14:0];
        end
      end
      if (ovr_set)            o_overrun <= 1'b1;
      else if (i_overrun_clr) o_overrun <= 1'b0;
    end
  end

endmodule
